pipeline_hilo_reader: RTL and testbench
=======================================

Name: pipeline_hilo_reader

Overview:
- Read side of the HI/LO register pair; serves mfhi/mflo for the decode/issue stage.
- Holds architectural HI/LO copies, updated from the late-ALU write stream (srl/sra never touch them; mult writes both; mthi/mtlo write one).
- Counts writes already issued to the late ALU but not yet landed, and stalls each read until every write issued at or before it has landed.
- Responds through a valid/ready handshake.

Parameters:
PEND_W, 2, width of each pending-write counter; at most 2^PEND_W-1 writes per register may be outstanding.
RESET_VAL, 32'h0, reset value of the HI and LO copies.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
iss_hi  in  1  a HI-writing op (mult/mthi) is issued to the late ALU this cycle
iss_lo  in  1  a LO-writing op (mult/mtlo) is issued this cycle
iss_ready  out  1  neither pending counter is at its maximum
wr_hi_en  in  1  late ALU writes HI this cycle
wr_lo_en  in  1  late ALU writes LO this cycle
wr_hi  in  32  HI write data
wr_lo  in  32  LO write data
rd_valid  in  1  mfhi/mflo request
rd_sel  in  1  0 = LO, 1 = HI
rd_ready  out  1  request accepted when rd_valid && rd_ready
resp_valid  out  1  response data valid
resp_ready  in  1  consumer takes the response
resp_data  out  32  value read
err_underflow  out  1  sticky: a write arrived while its counter was 0

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - hi_q/lo_q = RESET_VAL; pending counters = 0.
  - FSM = S_IDLE; resp_valid = 0; resp_data = 0; err_underflow = 0.
  - Reset mid-read aborts the read; no response is ever produced for it.
- Pending counters, one per register:
  - +1 on iss_x; -1 on wr_x_en; both in the same cycle leaves the counter unchanged.
  - A write with the counter at 0: the counter stays 0, the copy still updates, err_underflow is set.
  - iss_ready = 0 when either counter equals 2^PEND_W-1; an issue while iss_ready=0 is ignored.
- Copy update: wr_x_en loads hi_q/lo_q on the next edge; mult writes both registers in one cycle.
- FSM states: S_IDLE, S_WAIT, S_RESP. rd_ready = 1 only in S_IDLE.
- S_IDLE, on accept:
  - Latch the selector.
  - Latch the snapshot = the selected counter's value + iss_sel in that cycle - wr_sel_en in that cycle, saturated at 0.
  - Snapshot == 0: load resp_data from the copy, with the same-cycle write data taking precedence. Go to S_RESP; resp_valid rises at accept+1.
  - Otherwise go to S_WAIT.
- S_WAIT:
  - Each wr_sel_en decrements the snapshot. Later issues never affect it, so younger writes do not delay an older read.
  - When the snapshot reaches 0, load resp_data from the copy on the following cycle, then go to S_RESP.
- S_RESP:
  - resp_valid = 1; resp_data is held stable until resp_ready.
  - On resp_valid && resp_ready, return to S_IDLE. A new request is accepted no earlier than the next cycle.
- Simultaneous write and read of the same register on the data-load cycle: the write data wins.
- Widths: all data is 32 bit, with no extension or truncation.

Optional Feature:
- Macro: HILO_READ_BYPASS_EN.
- Defined:
  - In S_WAIT, the write that brings the snapshot 1->0 is captured directly into resp_data on that same edge.
  - The FSM goes straight to S_RESP, saving one cycle. Response at write cycle+1.
- Undefined:
  - Data is always loaded from hi_q/lo_q one cycle after the snapshot reaches 0. Response at write cycle+2.
- Both builds return identical values.

Decomposition:
- Package pipeline_hilo_pkg:
  - FSM state enum (S_IDLE, S_WAIT, S_RESP).
  - Selector constants SEL_LO=1'b0, SEL_HI=1'b1.
  - Default PEND_W.
- Sub-module pipeline_hilo_pendctr: saturating up/down counter with full flag and underflow pulse, instantiated twice (HI, LO).

Test Plan:
- Reset, then rd_valid with rd_sel=1 and no pending writes -> resp_valid at accept+1, resp_data=0x00000000; rst mid-S_WAIT -> resp_valid stays 0.
- iss_hi+iss_lo (mult); next cycle wr_hi=0xFFFFFFFF, wr_lo=0xFFFFFFFE; mflo accepted in the issue cycle -> waits; resp_data=0xFFFFFFFE at write+2 (write+1 with HILO_READ_BYPASS_EN).
- mthi 0x12345678 issued; mfhi accepted; then mthi 0xDEADBEEF issued before the first lands -> read returns 0x12345678, not 0xDEADBEEF.
- Three iss_lo with no writes (PEND_W=2) -> iss_ready=0; a fourth iss_lo is ignored; one wr_lo_en -> iss_ready=1.
- wr_hi_en=1 with the HI counter at 0 -> err_underflow=1 and stays 1 until rst; hi_q is updated.
- resp_ready held low for 5 cycles -> resp_valid and resp_data stable; rd_ready=0 throughout.

Source files
------------

// File: rtl/pipeline_hilo_pkg.sv
// Shared types and constants for the HI/LO read path.
package pipeline_hilo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  localparam int PEND_W_DEF = 2;

endpackage

// File: rtl/pipeline_hilo_reader_if.sv
// Issue, write-back, read-request and response signals of the HI/LO reader.
interface pipeline_hilo_reader_if;
  logic        iss_hi;
  logic        iss_lo;
  logic        iss_ready;
  logic        wr_hi_en;
  logic        wr_lo_en;
  logic [31:0] wr_hi;
  logic [31:0] wr_lo;
  logic        rd_valid;
  logic        rd_sel;
  logic        rd_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        err_underflow;

  modport master (
    output iss_hi, iss_lo, wr_hi_en, wr_lo_en, wr_hi, wr_lo,
           rd_valid, rd_sel, resp_ready,
    input  iss_ready, rd_ready, resp_valid, resp_data, err_underflow
  );

  modport slave (
    input  iss_hi, iss_lo, wr_hi_en, wr_lo_en, wr_hi, wr_lo,
           rd_valid, rd_sel, resp_ready,
    output iss_ready, rd_ready, resp_valid, resp_data, err_underflow
  );
endinterface

// File: rtl/pipeline_hilo_pendctr.sv
// Outstanding-write counter for one of HI/LO: saturates at both ends,
// flags full and pulses underflow when a write lands with nothing pending.
module pipeline_hilo_pendctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  assign full      = (count == CNT_MAX);
  assign underflow = dec && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_ONE;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pipeline_hilo_reader.sv
// mfhi/mflo read server: holds HI/LO copies and stalls each read until older writes land.
// Optional HILO_READ_BYPASS_EN captures the final awaited write directly into resp_data.
module pipeline_hilo_reader
  import pipeline_hilo_pkg::*;
#(
  parameter int          PEND_W    = PEND_W_DEF,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hilo_reader_if.slave bus
);

  localparam int            SW      = PEND_W + 1;
  localparam logic [SW-1:0] SNP_ONE = SW'(1);

  state_t            state, state_nxt;
  logic [31:0]       hi_q, lo_q, resp_q;
  logic [PEND_W-1:0] hi_cnt, lo_cnt;
  logic              hi_full, lo_full, hi_uf, lo_uf;
  logic              iss_ok, hi_inc, lo_inc;
  logic              err_q;
  logic              sel_q;
  logic [SW-1:0]     snap_q;

  logic              accept;
  logic              acc_iss, acc_wr;
  logic [SW-1:0]     snap_inc, snap_acc;
  logic [31:0]       acc_data;
  logic              cur_wr_en;
  logic [31:0]       cur_wr, load_data;
  logic              data_ld;
  logic [31:0]       data_nxt;

  assign iss_ok = !hi_full && !lo_full;
  assign hi_inc = bus.iss_hi && iss_ok;
  assign lo_inc = bus.iss_lo && iss_ok;

  pipeline_hilo_pendctr #(.PEND_W(PEND_W)) u_pend_hi (
    .clk(clk), .rst(rst), .inc(hi_inc), .dec(bus.wr_hi_en),
    .count(hi_cnt), .full(hi_full), .underflow(hi_uf)
  );

  pipeline_hilo_pendctr #(.PEND_W(PEND_W)) u_pend_lo (
    .clk(clk), .rst(rst), .inc(lo_inc), .dec(bus.wr_lo_en),
    .count(lo_cnt), .full(lo_full), .underflow(lo_uf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= RESET_VAL;
      lo_q  <= RESET_VAL;
      err_q <= 1'b0;
    end else begin
      if (bus.wr_hi_en) hi_q <= bus.wr_hi;
      if (bus.wr_lo_en) lo_q <= bus.wr_lo;
      if (hi_uf || lo_uf) err_q <= 1'b1;
    end
  end

  // Snapshot counts only writes issued up to and including the accept cycle.
  assign accept   = (state == S_IDLE) && bus.rd_valid;
  assign acc_iss  = (bus.rd_sel == SEL_HI) ? hi_inc : lo_inc;
  assign acc_wr   = (bus.rd_sel == SEL_HI) ? bus.wr_hi_en : bus.wr_lo_en;
  assign snap_inc = ((bus.rd_sel == SEL_HI) ? {1'b0, hi_cnt} : {1'b0, lo_cnt}) + SW'(acc_iss);
  assign snap_acc = (acc_wr && (snap_inc != '0)) ? snap_inc - SNP_ONE : snap_inc;
  assign acc_data = (bus.rd_sel == SEL_HI) ? (bus.wr_hi_en ? bus.wr_hi : hi_q)
                                           : (bus.wr_lo_en ? bus.wr_lo : lo_q);

  assign cur_wr_en = (sel_q == SEL_HI) ? bus.wr_hi_en : bus.wr_lo_en;
  assign cur_wr    = (sel_q == SEL_HI) ? bus.wr_hi : bus.wr_lo;
  assign load_data = cur_wr_en ? cur_wr : ((sel_q == SEL_HI) ? hi_q : lo_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (snap_acc == '0) ? S_RESP : S_WAIT;
`ifdef HILO_READ_BYPASS_EN
      S_WAIT: if ((snap_q == '0) || (cur_wr_en && (snap_q == SNP_ONE))) state_nxt = S_RESP;
`else
      S_WAIT: if (snap_q == '0) state_nxt = S_RESP;
`endif
      S_RESP: if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rd_ready   = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    data_ld        = 1'b0;
    data_nxt       = load_data;
    case (state)
      S_IDLE: begin
        if (accept && (snap_acc == '0)) begin
          data_ld  = 1'b1;
          data_nxt = acc_data;
        end
      end
      S_WAIT: begin
`ifdef HILO_READ_BYPASS_EN
        if (snap_q == '0) begin
          data_ld = 1'b1;
        end else if (cur_wr_en && (snap_q == SNP_ONE)) begin
          data_ld  = 1'b1;
          data_nxt = cur_wr;
        end
`else
        if (snap_q == '0) data_ld = 1'b1;
`endif
      end
      default: data_ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= SEL_LO;
      snap_q <= '0;
      resp_q <= 32'h0;
    end else begin
      if (accept) begin
        sel_q  <= bus.rd_sel;
        snap_q <= snap_acc;
      end else if ((state == S_WAIT) && cur_wr_en && (snap_q != '0)) begin
        snap_q <= snap_q - SNP_ONE;
      end
      if (data_ld) resp_q <= data_nxt;
    end
  end

  assign bus.iss_ready     = iss_ok;
  assign bus.resp_data     = resp_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_pipeline_hilo_reader.sv
// Bench for pipeline_hilo_reader: directed scenarios plus a randomized run against a cycle model.
// Honors HILO_READ_BYPASS_EN for response timing.
module tb_pipeline_hilo_reader;

  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pipeline_hilo_reader_if bus();

  pipeline_hilo_reader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iss_hi = 0; bus.iss_lo = 0; bus.wr_hi_en = 0; bus.wr_lo_en = 0;
    bus.wr_hi = 32'h0; bus.wr_lo = 32'h0; bus.rd_valid = 0; bus.rd_sel = 0;
    bus.resp_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cyc(); rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; cyc();
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL rst_resp_data got=%h exp=0", bus.resp_data); end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err_underflow); end
    checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL rst_iss_ready got=%b exp=1", bus.iss_ready); end
    checks++; if (bus.rd_ready !== 1'b1) begin failures++; $display("FAIL rst_rd_ready got=%b exp=1", bus.rd_ready); end
    rst = 0;
    bus.rd_valid = 1; bus.rd_sel = 1; cyc();
    bus.rd_valid = 0;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL rst_mfhi_valid got=%b exp=1", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL rst_mfhi_data got=%h exp=0", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mfhi_drop got=%b exp=0", bus.resp_valid); end
    // read parked in S_WAIT, then reset
    bus.iss_hi = 1; bus.rd_valid = 1; bus.rd_sel = 1; cyc();
    bus.iss_hi = 0; bus.rd_valid = 0;
    checks++; if (bus.rd_ready !== 1'b0) begin failures++; $display("FAIL rst_wait_rd_ready got=%b exp=0", bus.rd_ready); end
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_abort_valid cyc=%0d got=%b exp=0", i, bus.resp_valid); end
      cyc();
    end
    checks++; if (bus.rd_ready !== 1'b1) begin failures++; $display("FAIL rst_abort_rd_ready got=%b exp=1", bus.rd_ready); end
  endtask

  task automatic test_mult_wait();
    do_reset();
    bus.iss_hi = 1; bus.iss_lo = 1; bus.rd_valid = 1; bus.rd_sel = 0; cyc();
    idle_inputs();
    bus.wr_hi_en = 1; bus.wr_lo_en = 1; bus.wr_hi = 32'hFFFFFFFF; bus.wr_lo = 32'hFFFFFFFE;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL mult_wait_valid got=%b exp=0", bus.resp_valid); end
    cyc();
    idle_inputs();
`ifdef HILO_READ_BYPASS_EN
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL mult_w1_valid got=%b exp=1", bus.resp_valid); end
`else
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL mult_w1_valid got=%b exp=0", bus.resp_valid); end
`endif
    cyc();
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL mult_w2_valid got=%b exp=1", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo_data got=%h exp=fffffffe", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
    bus.rd_valid = 1; bus.rd_sel = 1; cyc(); bus.rd_valid = 0;
    checks++; if (bus.resp_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi_data got=%h exp=ffffffff", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
  endtask

  task automatic test_ordering();
    int waited;
    do_reset();
    bus.iss_hi = 1; cyc();
    bus.iss_hi = 0; bus.rd_valid = 1; bus.rd_sel = 1; cyc();
    bus.rd_valid = 0; bus.iss_hi = 1; cyc();
    bus.iss_hi = 0; bus.wr_hi_en = 1; bus.wr_hi = 32'h12345678; cyc();
    bus.wr_hi_en = 0;
    waited = 0;
    while (bus.resp_valid !== 1'b1 && waited < 6) begin cyc(); waited++; end
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL order_timeout got=%b exp=1", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h12345678) begin failures++; $display("FAIL order_data got=%h exp=12345678", bus.resp_data); end
    bus.wr_hi_en = 1; bus.wr_hi = 32'hDEADBEEF; cyc(); bus.wr_hi_en = 0;
    checks++; if (bus.resp_data !== 32'h12345678) begin failures++; $display("FAIL order_hold got=%h exp=12345678", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
    bus.rd_valid = 1; bus.rd_sel = 1; cyc(); bus.rd_valid = 0;
    checks++; if (bus.resp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL order_second got=%h exp=deadbeef", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL order_err got=%b exp=0", bus.err_underflow); end
  endtask

  task automatic test_full();
    bit exp_rdy;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.iss_lo = 1; cyc();
      exp_rdy = (i < PMAX);
      checks++; if (bus.iss_ready !== exp_rdy) begin failures++; $display("FAIL full_iss_ready n=%0d got=%b exp=%b", i, bus.iss_ready, exp_rdy); end
    end
    bus.iss_lo = 0;
    for (int i = 0; i < PMAX; i++) begin
      bus.wr_lo_en = 1; bus.wr_lo = 32'h100 + i; cyc();
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL full_release n=%0d got=%b exp=1", i, bus.iss_ready); end
    end
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL full_no_uf got=%b exp=0", bus.err_underflow); end
    bus.wr_lo = 32'h200; cyc(); bus.wr_lo_en = 0;
    checks++; if (bus.err_underflow !== 1'b1) begin failures++; $display("FAIL full_extra_uf got=%b exp=1", bus.err_underflow); end
    bus.rd_valid = 1; bus.rd_sel = 0; cyc(); bus.rd_valid = 0;
    checks++; if (bus.resp_data !== 32'h200) begin failures++; $display("FAIL full_lo_data got=%h exp=200", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
  endtask

  task automatic test_underflow();
    do_reset();
    bus.wr_hi_en = 1; bus.wr_hi = 32'hA5A55A5A; cyc(); bus.wr_hi_en = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky n=%0d got=%b exp=1", i, bus.err_underflow); end
      cyc();
    end
    bus.rd_valid = 1; bus.rd_sel = 1; cyc(); bus.rd_valid = 0;
    checks++; if (bus.resp_data !== 32'hA5A55A5A) begin failures++; $display("FAIL uf_hi_data got=%h exp=a5a55a5a", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
    rst = 1; cyc(); rst = 0;
    checks++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b exp=0", bus.err_underflow); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.iss_lo = 1; cyc(); bus.iss_lo = 0;
    bus.wr_lo_en = 1; bus.wr_lo = 32'hCAFEF00D; cyc(); bus.wr_lo_en = 0;
    bus.rd_valid = 1; bus.rd_sel = 0; cyc();
    bus.rd_sel = 1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL stall_valid n=%0d got=%b exp=1", i, bus.resp_valid); end
      checks++; if (bus.resp_data !== 32'hCAFEF00D) begin failures++; $display("FAIL stall_data n=%0d got=%h exp=cafef00d", i, bus.resp_data); end
      checks++; if (bus.rd_ready !== 1'b0) begin failures++; $display("FAIL stall_rd_ready n=%0d got=%b exp=0", i, bus.rd_ready); end
      cyc();
    end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.rd_ready !== 1'b1) begin failures++; $display("FAIL stall_rd_ready_back got=%b exp=1", bus.rd_ready); end
    cyc(); bus.rd_valid = 0;
    checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL stall_next_hi got=%h exp=0", bus.resp_data); end
    bus.resp_ready = 1; cyc(); bus.resp_ready = 0;
  endtask

  // Random traffic versus a model: per-register pending counts, copies, and
  // the read phase (0 idle, 1 waiting, 2 load-next, 3 responding).
  task automatic test_random();
    int          phi, plo, need, phase;
    logic [31:0] mhi, mlo, mdata;
    bit          merr, mrdy, ihi, ilo, rsel;
    bit          wsel_en;
    logic [31:0] wsel, csel;
    do_reset();
    phi = 0; plo = 0; need = 0; phase = 0;
    mhi = 32'h0; mlo = 32'h0; mdata = 32'h0; merr = 0; rsel = 0;
    for (int c = 0; c < 1500; c++) begin
      mrdy = (phi < PMAX) && (plo < PMAX);
      checks++; if (bus.resp_valid !== (phase == 3)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.resp_valid, phase == 3); end
      checks++; if (bus.rd_ready !== (phase == 0)) begin failures++; $display("FAIL rnd_rd_ready c=%0d got=%b exp=%b", c, bus.rd_ready, phase == 0); end
      checks++; if (bus.iss_ready !== mrdy) begin failures++; $display("FAIL rnd_iss_ready c=%0d got=%b exp=%b", c, bus.iss_ready, mrdy); end
      checks++; if (bus.err_underflow !== merr) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, bus.err_underflow, merr); end
      checks++; if (bus.resp_data !== mdata) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.resp_data, mdata); end

      bus.iss_hi     = ($urandom_range(0, 3) == 0);
      bus.iss_lo     = ($urandom_range(0, 3) == 0);
      bus.wr_hi_en   = (phi > 0) && ($urandom_range(0, 2) == 0);
      bus.wr_lo_en   = (plo > 0) && ($urandom_range(0, 2) == 0);
      bus.wr_hi      = $urandom;
      bus.wr_lo      = $urandom;
      bus.rd_valid   = $urandom_range(0, 1);
      bus.rd_sel     = $urandom_range(0, 1);
      bus.resp_ready = ($urandom_range(0, 2) != 0);

      ihi = bus.iss_hi && mrdy;
      ilo = bus.iss_lo && mrdy;
      if (phase == 0 && bus.rd_valid) rsel = bus.rd_sel;
      wsel_en = rsel ? bus.wr_hi_en : bus.wr_lo_en;
      wsel    = rsel ? bus.wr_hi : bus.wr_lo;
      csel    = rsel ? mhi : mlo;
      case (phase)
        0: if (bus.rd_valid) begin
             need = (rsel ? phi : plo) + int'(rsel ? ihi : ilo) - int'(wsel_en);
             if (need < 0) need = 0;
             if (need == 0) begin mdata = wsel_en ? wsel : csel; phase = 3; end
             else phase = 1;
           end
        1: if (wsel_en) begin
             need--;
             if (need == 0) begin
`ifdef HILO_READ_BYPASS_EN
               mdata = wsel; phase = 3;
`else
               phase = 2;
`endif
             end
           end
        2: begin mdata = wsel_en ? wsel : csel; phase = 3; end
        default: if (bus.resp_ready) phase = 0;
      endcase

      if (bus.wr_hi_en && phi == 0) merr = 1;
      if (bus.wr_lo_en && plo == 0) merr = 1;
      phi = phi + int'(ihi) - int'(bus.wr_hi_en); if (phi < 0) phi = 0;
      plo = plo + int'(ilo) - int'(bus.wr_lo_en); if (plo < 0) plo = 0;
      if (bus.wr_hi_en) mhi = bus.wr_hi;
      if (bus.wr_lo_en) mlo = bus.wr_lo;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult_wait();
    test_ordering();
    test_full();
    test_underflow();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
